// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder controller.
// Optional feature macro used by the controller: SERIAL_ADD_OVF_EN.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 64;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder built from two half-adder stages;
// the serial controller time-shares a single instance of this cell.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s1;
    logic c1;
    logic c2;

    // First half adder: a + b
    assign s1 = a ^ b;
    assign c1 = a & b;

    // Second half adder: partial sum + carry-in
    assign s  = s1 ^ ci;
    assign c2 = s1 & ci;

    assign co = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds a + b + cin LSB first over WIDTH
// cycles using one full-adder cell, then pulses done for one cycle.
// Optional macro SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
// rst_n is expected to arrive with its release already synchronised to clk.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;

    serial_fa_cell u_fa (
        .a  (sh_a[0]),
        .b  (sh_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    // Sequencer: operand capture, one bit per RUN cycle, registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            sh_a  <= '0;
            sh_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                        ovf   <= 1'b0;
`endif
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    carry <= fa_c;
                    if (cnt == LAST) begin
                        // carry here is the carry into the MSB, fa_c the carry out of it
                        cout  <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
                        ovf   <= carry ^ fa_c;
`endif
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): table vectors through a
// scoreboard queue plus hand-written busy/reset/back-to-back sequences.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    exp_t sb[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
        .cout  (cout),
        .ovf   (ovf)
`else
        .cout  (cout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done pulse seen, for the "exactly one pulse" checks
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t e;
        logic [W:0] full;
        full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
        return e;
    endfunction

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_sum"}, 64'(sum), 64'(e.sum));
        chk({tag, "_cout"}, 64'(cout), 64'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
`endif
    endtask

    // One operation; optionally fires spurious start pulses (new operands)
    // while busy: during RUN at k=2 and during DONE at k=W.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input exp_t e, input bit inject);
        int k;
        int d0;
        @(negedge clk);
        a = x; b = y; cin = c; start = 1'b1;
        sb.push_back(e);
        d0 = done_cnt;
        @(negedge clk);                       // k = 0: after the accepting edge
        start = 1'b0;
        chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
        k = 0;
        while (done !== 1'b1 && k < 3 * W) begin
            if (inject && k == 2) begin a = ~x; b = ~y; cin = ~c; start = 1'b1; end
            if (inject && k == 3) start = 1'b0;
            chk({tag, "_done_low"}, 64'(done), 64'd0);
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, 64'(k), 64'(W));
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd1);
        check_result(tag);
        if (inject) begin a = 8'hC3; b = 8'h99; cin = 1'b1; start = 1'b1; end
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_fall"}, 64'(done), 64'd0);
        chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_pulses"}, 64'(done_cnt - d0), 64'd1);
    endtask

    vec_t vt[7];

    initial begin
        int k;
        int prev;
        int seen;
        int d0;
        exp_t e;

        vt[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, sum: 8'h96, cout: 1'b0, ovf: 1'b1};
        vt[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vt[2] = '{a: 8'h7F, b: 8'h00, cin: 1'b1, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        vt[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0, ovf: 1'b0};
        vt[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
        vt[5] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};
        vt[6] = '{a: 8'h12, b: 8'h34, cin: 1'b1, sum: 8'h47, cout: 1'b0, ovf: 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;

        // Idle after reset with start low
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_done", 64'(done), 64'd0);
            chk("idle_sum", 64'(sum), 64'd0);
            chk("idle_cout", 64'(cout), 64'd0);
        end

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            e.sum = vt[i].sum; e.cout = vt[i].cout; e.ovf = vt[i].ovf;
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, e, 1'b0);
            // result holds in IDLE until the next accepted start
            chk($sformatf("vec%0d_hold_sum", i), 64'(sum), 64'(vt[i].sum));
        end

        // Random operands against the arithmetic model
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            logic c;
            x = W'($urandom); y = W'($urandom); c = 1'($urandom);
            run_op($sformatf("rnd%0d", i), x, y, c, model(x, y, c), 1'b0);
        end

        // start pulses while busy (RUN and DONE) are ignored
        e.sum = 8'h96; e.cout = 1'b0; e.ovf = 1'b1;
        run_op("busy_start", 8'h5A, 8'h3C, 1'b0, e, 1'b1);

        // Reset asserted mid-RUN aborts the operation
        @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        sb.push_back(model(8'hAA, 8'h55, 1'b1));
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sum", 64'(sum), 64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("abort_ovf", 64'(ovf), 64'd0);
`endif
        void'(sb.pop_front());
        d0 = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * W) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        chk("abort_idle_busy", 64'(busy), 64'd0);
        e.sum = 8'h47; e.cout = 1'b0; e.ovf = 1'b0;
        run_op("after_abort", 8'h12, 8'h34, 1'b1, e, 1'b0);

        // start held high: back-to-back operations, re-accepted in the IDLE after DONE
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(model(8'h01, 8'h01, 1'b0));
        prev = -1; seen = 0; k = 0;
        while (seen < 3 && k < 5 * (W + 2)) begin
            @(negedge clk);
            k++;
            if (done === 1'b1) begin
                check_result($sformatf("held%0d", seen));
                chk($sformatf("held%0d_sum02", seen), 64'(sum), 64'h02);
                if (prev >= 0) chk("held_period", 64'(k - prev), 64'(W + 2));
                prev = k;
                seen++;
                if (seen == 3) start = 1'b0;
            end
        end
        chk("held_count", 64'(seen), 64'd3);
        repeat (3) @(negedge clk);
        chk("held_stop_busy", 64'(busy), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always ends
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
